// File: rtl/lnrv_gpr_sb.sv
// lnrv general-purpose register file with a per-register busy scoreboard,
// fixed-priority writeback ports and optional same-cycle write-to-read bypass.
module lnrv_gpr_sb #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_RD     = 2,
  parameter int unsigned NUM_WR     = 2,
  parameter int unsigned BYPASS     = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] rd_idx,
  output logic [NUM_RD*DATA_WIDTH-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_busy,
  input  logic [NUM_WR-1:0]            wr_vld,
  output logic [NUM_WR-1:0]            wr_rdy,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] wr_idx,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
  input  logic                         sb_set_vld,
  input  logic [ADDR_WIDTH-1:0]        sb_set_idx,
  output logic                         sb_set_rdy,
  output logic [DATA_WIDTH-1:0]        ra
);

  localparam int unsigned REG_COUNT = 1 << ADDR_WIDTH;

  typedef logic [DATA_WIDTH-1:0] word_t;
  typedef logic [ADDR_WIDTH-1:0] addr_t;

  word_t                regs_q [REG_COUNT];
  word_t                regs_d [REG_COUNT];
  logic [REG_COUNT-1:0] busy_q;
  logic [REG_COUNT-1:0] busy_d;

  addr_t                rd_idx_a  [NUM_RD];
  addr_t                wr_idx_a  [NUM_WR];
  word_t                wr_data_a [NUM_WR];
  logic [NUM_WR-1:0]    wr_blk;
  logic [NUM_WR-1:0]    wr_acc;
  logic                 sb_wr_hit;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd_unpack
    assign rd_idx_a[p] = rd_idx[p*ADDR_WIDTH +: ADDR_WIDTH];
  end

  for (genvar k = 0; k < NUM_WR; k++) begin : g_wr_unpack
    assign wr_idx_a[k]  = wr_idx[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wr_data_a[k] = wr_data[k*DATA_WIDTH +: DATA_WIDTH];
  end

  // A port is held off when any lower-numbered valid port targets the same nonzero index.
  always_comb begin
    wr_blk = '0;
    for (int unsigned k = 1; k < NUM_WR; k++) begin
      for (int unsigned j = 0; j < k; j++) begin
        if (wr_vld[j] && (wr_idx_a[j] == wr_idx_a[k]) && (wr_idx_a[k] != '0)) begin
          wr_blk[k] = 1'b1;
        end
      end
    end
  end

  assign wr_acc = wr_vld & ~wr_blk;
  assign wr_rdy = ~wr_vld | ~wr_blk;

  always_comb begin
    sb_wr_hit = 1'b0;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_acc[k] && (wr_idx_a[k] == sb_set_idx)) begin
        sb_wr_hit = 1'b1;
      end
    end
  end

  assign sb_set_rdy = ~busy_q[sb_set_idx] | sb_wr_hit | (sb_set_idx == '0);

  // Writes clear busy; an accepted set is applied last so it wins a same-index clear.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    for (int unsigned k = 0; k < NUM_WR; k++) begin
      if (wr_acc[k] && (wr_idx_a[k] != '0)) begin
        regs_d[wr_idx_a[k]] = wr_data_a[k];
        busy_d[wr_idx_a[k]] = 1'b0;
      end
    end
    if (sb_set_vld && sb_set_rdy && (sb_set_idx != '0)) begin
      busy_d[sb_set_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    for (int unsigned p = 0; p < NUM_RD; p++) begin
      if (rd_idx_a[p] != '0) begin
        rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_idx_a[p]];
        rd_busy[p]                          = busy_q[rd_idx_a[p]];
        if (BYPASS != 0) begin
          for (int unsigned k = 0; k < NUM_WR; k++) begin
            if (wr_acc[k] && (wr_idx_a[k] == rd_idx_a[p])) begin
              rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wr_data_a[k];
              rd_busy[p]                          = 1'b0;
            end
          end
        end
      end
    end
  end

  assign ra = regs_q[1];

endmodule
